// File: rtl/branch_redirect_if.sv
// Bundle between the EX-stage branch resolver / hazard unit and the redirect controller.
// The master side drives branch decisions and stalls; the slave side returns redirect, flush and stats.
interface branch_redirect_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic              Branch;
  logic              Branch_out;
  logic [ADDR_W-1:0] BranchTarget;
  logic              StallIn;
  logic              PCSrc;
  logic [ADDR_W-1:0] PCRedirect;
  logic              FlushIFID;
  logic              FlushIDEX;
  logic              Busy;
  logic [CNT_W-1:0]  BranchCount;
  logic [CNT_W-1:0]  TakenCount;

  modport master (
    output Branch, Branch_out, BranchTarget, StallIn,
    input  PCSrc, PCRedirect, FlushIFID, FlushIDEX, Busy, BranchCount, TakenCount
  );

  modport slave (
    input  Branch, Branch_out, BranchTarget, StallIn,
    output PCSrc, PCRedirect, FlushIFID, FlushIDEX, Busy, BranchCount, TakenCount
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: latches taken-branch targets, drives the fetch redirect,
// squashes wrong-path IF/ID and ID/EX contents and keeps saturating branch statistics.
//
//   state  | meaning
//   IDLE   | no redirect outstanding, resolving branches from EX
//   PEND   | taken branch latched while the pipeline is stalled
//   REDIR  | PCSrc and both flushes asserted, held across stalls
//   SQUASH | flushes held for the remaining unstalled flush cycles
module branch_redirect_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic              Clk,
  input logic              Rst,
  branch_redirect_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    REDIR  = 2'd2,
    SQUASH = 2'd3
  } state_t;

  localparam logic [2:0] SQUASH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t            state_q;
  logic              pcsrc_q;
  logic              flush_q;
  logic [ADDR_W-1:0] target_q;
  logic [2:0]        flush_cnt_q;
  logic [CNT_W-1:0]  bcnt_q;
  logic [CNT_W-1:0]  tcnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= IDLE;
      pcsrc_q     <= 1'b0;
      flush_q     <= 1'b0;
      target_q    <= '0;
      flush_cnt_q <= '0;
      bcnt_q      <= '0;
      tcnt_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.Branch) begin
            // A stalled branch is re-presented by the hazard unit, so count it only when unstalled.
            if (!bus.StallIn) begin
              bcnt_q <= sat_inc(bcnt_q);
              if (bus.Branch_out) tcnt_q <= sat_inc(tcnt_q);
            end
            if (bus.Branch_out) begin
              target_q <= bus.BranchTarget;
              if (bus.StallIn) begin
                state_q <= PEND;
              end else begin
                state_q <= REDIR;
                pcsrc_q <= 1'b1;
                flush_q <= 1'b1;
              end
            end
          end
        end
        PEND: begin
          if (!bus.StallIn) begin
            bcnt_q  <= sat_inc(bcnt_q);
            tcnt_q  <= sat_inc(tcnt_q);
            state_q <= REDIR;
            pcsrc_q <= 1'b1;
            flush_q <= 1'b1;
          end
        end
        REDIR: begin
          if (!bus.StallIn) begin
            pcsrc_q <= 1'b0;
            if (FLUSH_CYCLES == 1) begin
              state_q <= IDLE;
              flush_q <= 1'b0;
            end else begin
              state_q     <= SQUASH;
              flush_cnt_q <= SQUASH_LOAD;
            end
          end
        end
        SQUASH: begin
          if (!bus.StallIn) begin
            if (flush_cnt_q <= 3'd1) begin
              state_q     <= IDLE;
              flush_q     <= 1'b0;
              flush_cnt_q <= '0;
            end else begin
              flush_cnt_q <= flush_cnt_q - 3'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          pcsrc_q <= 1'b0;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PCSrc       = pcsrc_q;
  assign bus.PCRedirect  = target_q;
  assign bus.FlushIFID   = flush_q;
  assign bus.FlushIDEX   = flush_q;
  assign bus.Busy        = (state_q != IDLE);
  assign bus.BranchCount = bcnt_q;
  assign bus.TakenCount  = tcnt_q;

endmodule
